drive_sequencer: RTL and testbench
==================================

// Module: drive_sequencer
// PURPOSE
//  Sits between line-tracker steering FSM and motor PWM driver; owns motor command (dir, speed).
//  Passes tracker command through normally; on filtered sonar obstacle runs a timed
//  brake -> reverse -> turn maneuver with retry limit, then hands control back. Latches FAULT on retry exhaustion.
// PARAMETERS
//  CLK_PER_MS  100000  clk cycles per 1 ms phase tick (>=2)
//  NEAR_CM     24      obstacle threshold; distance < NEAR_CM is "near"
//  NEAR_CNT    3       consecutive near ms-ticks needed to trigger maneuver (>=1)
//  BRAKE_MS    200     brake phase length, ms (>=1)
//  REVERSE_MS  400     reverse phase length, ms (>=1)
//  TURN_MS     300     turn phase length, ms (>=1)
//  REV_SPEED   780     speed during REVERSE (10-bit)
//  TURN_SPEED  840     speed during TURN (10-bit)
//  TURN_DIR    2'd1    dir code used in TURN (LEFT)
//  MAX_RETRY   3       TURN re-entries allowed before FAULT
//  RAMP_STEP   16      speed increment per ms tick (DRIVE_RAMP_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-high
//  stop         in   1   operator stop; forces speed 0, aborts maneuver, clears fault
//  distance     in   8   sonar distance, cm (level, asynchronous updates tolerated)
//  track_dir    in   2   tracker requested direction
//  track_speed  in   10  tracker requested speed
//  dir          out  2   motor direction command (registered)
//  speed        out  10  motor speed command (registered)
//  busy         out  1   1 while in BRAKE/REVERSE/TURN
//  fault        out  1   1 while in FAULT
// BEHAVIOUR
//  Reset: state FOLLOW, dir=FORWARD, speed=0, busy=0, fault=0, all counters 0.
//  Tick: prescaler counts 0..CLK_PER_MS-1; tick=1 for one clk at terminal count.
//  Near filter: on tick, near_cnt++ (saturate NEAR_CNT) if distance<NEAR_CM else near_cnt=0;
//   near = (near_cnt==NEAR_CNT). distance==NEAR_CM is not near.
//  Phase timer: loaded with phase length on state entry, decremented on tick; expiry at 1->0.
//  States / transitions (evaluated every clk):
//   FOLLOW : dir=track_dir, speed=track_speed; near -> BRAKE, retry=0.
//   BRAKE  : dir held, speed=0; expiry -> REVERSE.
//   REVERSE: dir=BACKWARD, speed=REV_SPEED; expiry -> TURN.
//   TURN   : dir=TURN_DIR, speed=TURN_SPEED; expiry: !near -> FOLLOW, near_cnt=0;
//            near & retry<MAX_RETRY -> BRAKE, retry++; near & retry==MAX_RETRY -> FAULT.
//   FAULT  : dir held, speed=0, fault=1; exits only via stop -> FOLLOW.
//  stop=1 (any state): next clk state=FOLLOW, speed=0, timer/retry/near_cnt cleared; held while stop=1.
//  stop has priority over every simultaneous transition, incl. expiry and near.
//  Latency: inputs -> dir/speed one clk (registered outputs), without ramp.
//  Prescaler free-runs across state changes; first phase tick may be <1 ms short (accepted).
// CONFIGURATION
//  DRIVE_RAMP_EN defined: speed rises toward target by RAMP_STEP per tick, saturating at target;
//   decreases (incl. to 0, stop, brake) apply next clk; dir change forces speed=0 for one clk first.
//  DRIVE_RAMP_EN undefined: speed = target one clk later, no ramp logic instantiated.
// STRUCTURE
//  drive_pkg: dir codes BACKWARD=0 LEFT=1 RIGHT=2 FORWARD=3; state enum
//   FOLLOW/BRAKE/REVERSE/TURN/FAULT; SPEED_W=10, DIST_W=8.
//  Sub-module ms_tick (prescaler, param CLK_PER_MS, out tick) shared with other timed blocks.
// TESTING  (bench params: CLK_PER_MS=10, NEAR_CNT=3, BRAKE/REVERSE/TURN_MS=2, MAX_RETRY=1)
//  Reset, distance=100, track_dir=LEFT, track_speed=870 -> after 1 clk dir=1, speed=870, busy=0.
//  distance=10 from t0 -> BRAKE on 3rd tick (~30 clk): speed=0; +20 clk REVERSE dir=0 speed=780;
//   +20 clk TURN dir=1 speed=840; distance=100 at TURN -> expiry returns FOLLOW, busy=0.
//  distance=24 held 10 ticks -> never leaves FOLLOW; distance=23 for 2 ticks then 30 -> no trigger.
//  distance=10 held -> BRAKE,REVERSE,TURN,BRAKE(retry1),REVERSE,TURN -> FAULT: fault=1, speed=0;
//   stop pulse 1 clk -> FOLLOW, fault=0 next clk.
//  stop=1 mid-REVERSE coincident with timer expiry -> next clk state FOLLOW, speed=0, not TURN.
//  DRIVE_RAMP_EN, RAMP_STEP=16: track_speed 0->64 -> speed 16,32,48,64 on successive ticks;
//   then track_speed=0 -> speed=0 next clk; track_dir change at speed 64 -> speed 0 for one clk.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared definitions for the drive sequencer slice.
//   SPEED_W / DIST_W : widths of speed commands and sonar distance
//   BACKWARD/LEFT/RIGHT/FORWARD : motor direction codes
//   drive_state_t    : sequencer state (FOLLOW/BRAKE/REVERSE/TURN/FAULT)
//   ramp_up()        : one ramp step toward a target, saturating at the target
package drive_pkg;

   localparam int SPEED_W = 10;
   localparam int DIST_W  = 8;

   localparam logic [1:0] BACKWARD = 2'd0;
   localparam logic [1:0] LEFT     = 2'd1;
   localparam logic [1:0] RIGHT    = 2'd2;
   localparam logic [1:0] FORWARD  = 2'd3;

   typedef enum logic [2:0] {
      FOLLOW  = 3'd0,
      BRAKE   = 3'd1,
      REVERSE = 3'd2,
      TURN    = 3'd3,
      FAULT   = 3'd4
   } drive_state_t;

   // Adds step to cur but never overshoots tgt (sum computed one bit wider
   // so a step near full scale cannot wrap).
   function automatic logic [SPEED_W-1:0] ramp_up(
      input logic [SPEED_W-1:0] cur,
      input logic [SPEED_W-1:0] tgt,
      input logic [SPEED_W-1:0] step
   );
      logic [SPEED_W:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      if (sum >= {1'b0, tgt}) return tgt;
      else                    return sum[SPEED_W-1:0];
   endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Signal bundle between the tracker/sonar side and the drive sequencer.
//   stop, distance, track_dir, track_speed : commands into the sequencer
//   dir, speed, busy, fault                : registered motor command and status
//   state                                  : debug view of the sequencer FSM
// Handshake: there is no valid/ready pair on this bundle. Every input is a
// level sampled on each clk; every output is a level that holds its value
// until the sequencer changes it. Nothing is ever "consumed".
interface drive_sequencer_if;
   import drive_pkg::*;

   logic                stop;
   logic [DIST_W-1:0]   distance;
   logic [1:0]          track_dir;
   logic [SPEED_W-1:0]  track_speed;
   logic [1:0]          dir;
   logic [SPEED_W-1:0]  speed;
   logic                busy;
   logic                fault;
   drive_state_t        state;

   modport master (
      output stop, distance, track_dir, track_speed,
      input  dir, speed, busy, fault, state
   );

   modport slave (
      input  stop, distance, track_dir, track_speed,
      output dir, speed, busy, fault, state
   );

endinterface

// File: rtl/drive_sequencer_ms_tick.sv
// ms_tick: free-running prescaler producing a one-clk tick every CLK_PER_MS clks.
//   clk, rst : clock, asynchronous active-high reset
//   tick     : high for one clk while the counter sits at its terminal count
module ms_tick #(
   parameter int CLK_PER_MS = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int             CW   = $clog2(CLK_PER_MS);
   localparam logic [CW-1:0]  TERM = CW'(CLK_PER_MS - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (cnt == TERM) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == TERM);

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: owns the motor command between the line tracker and the PWM
// driver. Normally passes the tracker command through; when the filtered sonar
// reports an obstacle it runs a timed brake -> reverse -> turn maneuver, retries
// up to MAX_RETRY times, and latches FAULT when retries run out.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : drive_sequencer_if.slave (stop/distance/track_* in,
//              dir/speed/busy/fault/state out, all outputs registered)
// Optional build macro DRIVE_RAMP_EN: speed rises toward its target by
// RAMP_STEP per ms tick; decreases and direction changes act immediately.
// The ramp is a second register stage after the FSM command register.
module drive_sequencer
   import drive_pkg::*;
#(
   parameter int         CLK_PER_MS = 100000,
   parameter int         NEAR_CM    = 24,
   parameter int         NEAR_CNT   = 3,
   parameter int         BRAKE_MS   = 200,
   parameter int         REVERSE_MS = 400,
   parameter int         TURN_MS    = 300,
   parameter int         REV_SPEED  = 780,
   parameter int         TURN_SPEED = 840,
   parameter logic [1:0] TURN_DIR   = LEFT,
   parameter int         MAX_RETRY  = 3
`ifdef DRIVE_RAMP_EN
   ,parameter int        RAMP_STEP  = 16
`endif
) (
   input logic              clk,
   input logic              rst,
   drive_sequencer_if.slave bus
);

   localparam int TW = 16;
   localparam int NW = $clog2(NEAR_CNT + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   localparam logic [DIST_W-1:0]  NEAR_TH   = DIST_W'(NEAR_CM);
   localparam logic [NW-1:0]      NEAR_MAX  = NW'(NEAR_CNT);
   localparam logic [RW-1:0]      RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [TW-1:0]      T_ONE     = TW'(1);
   localparam logic [TW-1:0]      T_BRAKE   = TW'(BRAKE_MS);
   localparam logic [TW-1:0]      T_REVERSE = TW'(REVERSE_MS);
   localparam logic [TW-1:0]      T_TURN    = TW'(TURN_MS);
   localparam logic [SPEED_W-1:0] SPD_REV   = SPEED_W'(REV_SPEED);
   localparam logic [SPEED_W-1:0] SPD_TURN  = SPEED_W'(TURN_SPEED);

   logic               tick;
   logic [NW-1:0]      near_cnt;
   logic               near;
   logic               expiry;
   logic               clr_near;
   drive_state_t       state;
   logic [TW-1:0]      timer;
   logic [RW-1:0]      retry;
   logic [1:0]         cmd_dir;
   logic [SPEED_W-1:0] cmd_spd;
   logic               busy_q;
   logic               fault_q;
   logic [1:0]         dir_out;
   logic [SPEED_W-1:0] speed_out;

   ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign near     = (near_cnt == NEAR_MAX);
   assign expiry   = tick && (timer == T_ONE);
   // Leaving TURN back to FOLLOW restarts obstacle filtering from scratch.
   assign clr_near = (state == TURN) && expiry && !near;

   // Obstacle filter: count consecutive near ms-ticks, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         near_cnt <= '0;
      end else if (bus.stop || clr_near) begin
         near_cnt <= '0;
      end else if (tick) begin
         if (bus.distance < NEAR_TH) begin
            if (near_cnt != NEAR_MAX) near_cnt <= near_cnt + 1'b1;
         end else begin
            near_cnt <= '0;
         end
      end
   end

   // Sequencer FSM. cmd_dir/cmd_spd always hold the command for the state
   // being entered, so the motor sees the new phase on the transition clk.
   // Loads of the phase timer below override the generic decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= FOLLOW;
         timer   <= '0;
         retry   <= '0;
         cmd_dir <= FORWARD;
         cmd_spd <= '0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else if (bus.stop) begin
         state   <= FOLLOW;
         timer   <= '0;
         retry   <= '0;
         cmd_spd <= '0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         if (tick && (timer != '0)) timer <= timer - 1'b1;
         case (state)
            FOLLOW: begin
               if (near) begin
                  state   <= BRAKE;
                  timer   <= T_BRAKE;
                  retry   <= '0;
                  cmd_spd <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  cmd_dir <= bus.track_dir;
                  cmd_spd <= bus.track_speed;
               end
            end
            BRAKE: begin
               if (expiry) begin
                  state   <= REVERSE;
                  timer   <= T_REVERSE;
                  cmd_dir <= BACKWARD;
                  cmd_spd <= SPD_REV;
               end
            end
            REVERSE: begin
               if (expiry) begin
                  state   <= TURN;
                  timer   <= T_TURN;
                  cmd_dir <= TURN_DIR;
                  cmd_spd <= SPD_TURN;
               end
            end
            TURN: begin
               if (expiry) begin
                  if (!near) begin
                     state   <= FOLLOW;
                     cmd_dir <= bus.track_dir;
                     cmd_spd <= bus.track_speed;
                     busy_q  <= 1'b0;
                  end else if (retry < RETRY_MAX) begin
                     state   <= BRAKE;
                     timer   <= T_BRAKE;
                     retry   <= retry + 1'b1;
                     cmd_spd <= '0;
                  end else begin
                     state   <= FAULT;
                     cmd_spd <= '0;
                     busy_q  <= 1'b0;
                     fault_q <= 1'b1;
                  end
               end
            end
            FAULT: begin
               cmd_spd <= '0;
            end
            default: begin
               state   <= FOLLOW;
               cmd_spd <= '0;
               busy_q  <= 1'b0;
               fault_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DRIVE_RAMP_EN
   localparam logic [SPEED_W-1:0] STEP = SPEED_W'(RAMP_STEP);

   // A direction change first drops speed to zero; the ramp then restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_out   <= FORWARD;
         speed_out <= '0;
      end else if (cmd_dir != dir_out) begin
         dir_out   <= cmd_dir;
         speed_out <= '0;
      end else if (cmd_spd < speed_out) begin
         speed_out <= cmd_spd;
      end else if (tick) begin
         speed_out <= ramp_up(speed_out, cmd_spd, STEP);
      end
   end
`else
   assign dir_out   = cmd_dir;
   assign speed_out = cmd_spd;
`endif

   assign bus.dir   = dir_out;
   assign bus.speed = speed_out;
   assign bus.busy  = busy_q;
   assign bus.fault = fault_q;
   assign bus.state = state;

endmodule

// File: tb/tb_drive_sequencer.sv
module tb_drive_sequencer;
   import drive_pkg::*;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];

   drive_sequencer_if bus();

   drive_sequencer #(
      .CLK_PER_MS (10),
      .NEAR_CM    (24),
      .NEAR_CNT   (3),
      .BRAKE_MS   (2),
      .REVERSE_MS (2),
      .TURN_MS    (2),
      .REV_SPEED  (780),
      .TURN_SPEED (840),
      .TURN_DIR   (2'd1),
      .MAX_RETRY  (1)
`ifdef DRIVE_RAMP_EN
      ,.RAMP_STEP (16)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input drive_state_t s, input int budget, output int n);
      n = 0;
      while (bus.state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wait_state_%0d", int'(s)), 32'(bus.state), 32'(s));
   endtask

   task automatic wait_speed_change(input int budget);
      logic [SPEED_W-1:0] prev;
      int n;
      prev = bus.speed;
      n = 0;
      while (bus.speed === prev && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("speed_change_timeout", 32'(n), 32'(budget - 1));
   endtask

   // driver
   task automatic drive(input logic s, input logic [7:0] d, input logic [1:0] td,
                        input logic [9:0] ts);
      bus.stop        = s;
      bus.distance    = d;
      bus.track_dir   = td;
      bus.track_speed = ts;
   endtask

   typedef struct {
      logic       stop;
      logic [7:0] distance;
      logic [1:0] track_dir;
      logic [9:0] track_speed;
      logic [1:0] exp_dir;
      logic [9:0] exp_speed;
      logic       exp_busy;
      logic       exp_fault;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int n;
      int bad;
      logic [31:0] e;

      // Pass-through vectors in FOLLOW, one clk latency each.
      vecs[0] = '{1'b0, 8'd100, 2'd1, 10'd870,  2'd1, 10'd870,  1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'd100, 2'd3, 10'd0,    2'd3, 10'd0,    1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'd100, 2'd2, 10'd1023, 2'd2, 10'd1023, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'd100, 2'd0, 10'd1,    2'd0, 10'd1,    1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'd100, 2'd3, 10'd500,  2'd0, 10'd0,    1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'd24,  2'd3, 10'd500,  2'd3, 10'd500,  1'b0, 1'b0};
      vecs[6] = '{1'b0, 8'd100, 2'd1, 10'd512,  2'd1, 10'd512,  1'b0, 1'b0};

      rst = 1'b1;
      drive(1'b0, 8'd100, 2'd1, 10'd870);
      repeat (3) @(negedge clk);
      check("reset_state", 32'(bus.state), 32'(FOLLOW));
      check("reset_dir",   32'(bus.dir),   32'(FORWARD));
      check("reset_speed", 32'(bus.speed), 32'd0);
      check("reset_busy",  32'(bus.busy),  32'd0);
      check("reset_fault", 32'(bus.fault), 32'd0);
      rst = 1'b0;

`ifndef DRIVE_RAMP_EN
      // Table-driven pass-through.
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].stop, vecs[i].distance, vecs[i].track_dir, vecs[i].track_speed);
         exp_q.push_back({18'd0, vecs[i].exp_dir, vecs[i].exp_speed,
                          vecs[i].exp_busy, vecs[i].exp_fault});
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("vec%0d_dir", i),   32'(bus.dir),   32'(e[13:12]));
         check($sformatf("vec%0d_speed", i), 32'(bus.speed), 32'(e[11:2]));
         check($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(e[1]));
         check($sformatf("vec%0d_fault", i), 32'(bus.fault), 32'(e[0]));
      end

      // distance==NEAR_CM is never near; 2 near ticks are not enough.
      bad = 0;
      drive(1'b0, 8'd24, 2'd3, 10'd500);
      repeat (100) begin @(negedge clk); if (bus.state !== FOLLOW || bus.busy !== 1'b0) bad++; end
      check("at_threshold_no_trigger", 32'(bad), 32'd0);
      bad = 0;
      bus.distance = 8'd23;
      repeat (20) begin @(negedge clk); if (bus.state !== FOLLOW) bad++; end
      bus.distance = 8'd30;
      repeat (40) begin @(negedge clk); if (bus.state !== FOLLOW) bad++; end
      check("two_near_ticks_no_trigger", 32'(bad), 32'd0);

      // Full maneuver, obstacle clears during TURN.
      drive(1'b0, 8'd10, 2'd1, 10'd870);
      wait_state(BRAKE, 40, n);
      check("brake_after_3_ticks", 32'(n >= 22 && n <= 31), 32'd1);
      check("brake_speed", 32'(bus.speed), 32'd0);
      check("brake_dir",   32'(bus.dir),   32'd1);
      check("brake_busy",  32'(bus.busy),  32'd1);
      wait_state(REVERSE, 40, n);
      check("brake_len", 32'(n), 32'd19);
      check("reverse_dir",   32'(bus.dir),   32'(BACKWARD));
      check("reverse_speed", 32'(bus.speed), 32'd780);
      wait_state(TURN, 40, n);
      check("reverse_len", 32'(n), 32'd20);
      check("turn_dir",   32'(bus.dir),   32'd1);
      check("turn_speed", 32'(bus.speed), 32'd840);
      bus.distance = 8'd100;
      wait_state(FOLLOW, 40, n);
      check("turn_len",      32'(n),         32'd20);
      check("return_busy",   32'(bus.busy),  32'd0);
      check("return_speed",  32'(bus.speed), 32'd870);

      // Obstacle persists: one retry, then FAULT; stop clears it.
      drive(1'b0, 8'd10, 2'd3, 10'd500);
      wait_state(BRAKE, 40, n);
      wait_state(REVERSE, 40, n);
      wait_state(TURN, 40, n);
      wait_state(BRAKE, 40, n);
      check("retry_brake_len_turn", 32'(n), 32'd20);
      check("retry_brake_busy", 32'(bus.busy), 32'd1);
      check("retry_brake_speed", 32'(bus.speed), 32'd0);
      wait_state(REVERSE, 40, n);
      check("retry_brake_len", 32'(n), 32'd20);
      wait_state(TURN, 40, n);
      wait_state(FAULT, 40, n);
      check("fault_after_turn", 32'(n), 32'd20);
      check("fault_flag",  32'(bus.fault), 32'd1);
      check("fault_speed", 32'(bus.speed), 32'd0);
      check("fault_busy",  32'(bus.busy),  32'd0);
      check("fault_dir",   32'(bus.dir),   32'd1);
      bad = 0;
      bus.distance = 8'd100;
      repeat (30) begin @(negedge clk); if (bus.state !== FAULT) bad++; end
      check("fault_is_sticky", 32'(bad), 32'd0);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("stop_clears_state", 32'(bus.state), 32'(FOLLOW));
      check("stop_clears_fault", 32'(bus.fault), 32'd0);
      check("stop_speed",        32'(bus.speed), 32'd0);
      @(negedge clk);
      check("after_stop_speed", 32'(bus.speed), 32'd500);
      check("after_stop_dir",   32'(bus.dir),   32'd3);

      // stop lands on the same clk as REVERSE expiry: FOLLOW wins, not TURN.
      bus.distance = 8'd10;
      wait_state(BRAKE, 40, n);
      wait_state(REVERSE, 40, n);
      repeat (19) @(negedge clk);
      check("pre_stop_still_reverse", 32'(bus.state), 32'(REVERSE));
      bus.stop = 1'b1;
      @(negedge clk);
      check("stop_at_expiry_state", 32'(bus.state), 32'(FOLLOW));
      check("stop_at_expiry_speed", 32'(bus.speed), 32'd0);
      check("stop_at_expiry_busy",  32'(bus.busy),  32'd0);
      @(negedge clk);
      check("stop_held_state", 32'(bus.state), 32'(FOLLOW));
      check("stop_held_speed", 32'(bus.speed), 32'd0);
      drive(1'b0, 8'd100, 2'd3, 10'd500);
      @(negedge clk);
      check("stop_release_speed", 32'(bus.speed), 32'd500);
`else
      // Ramp build: rise by 16 per tick, immediate decreases and dir changes.
      drive(1'b0, 8'd100, 2'd3, 10'd64);
      for (int k = 1; k <= 4; k++) begin
         wait_speed_change(25);
         check($sformatf("ramp_step%0d", k), 32'(bus.speed), 32'(16 * k));
      end
      repeat (25) @(negedge clk);
      check("ramp_saturates", 32'(bus.speed), 32'd64);
      bus.track_speed = 10'd0;
      repeat (2) @(negedge clk);
      check("ramp_drop_to_zero", 32'(bus.speed), 32'd0);
      bus.track_speed = 10'd64;
      for (int k = 1; k <= 4; k++) begin
         wait_speed_change(25);
         check($sformatf("ramp_again%0d", k), 32'(bus.speed), 32'(16 * k));
      end
      bus.track_dir = 2'd2;
      repeat (2) @(negedge clk);
      check("dir_change_speed", 32'(bus.speed), 32'd0);
      check("dir_change_dir",   32'(bus.dir),   32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
